// File: rtl/password_access_fsm.sv
// password_access_fsm
// Four-digit password gate placed in front of the game's guess register.
// Each digit is confirmed by a one-cycle enter pulse. A correct sequence
// raises enable until logout. MAX_FAIL consecutive failures trigger a
// timed lockout, and all keypad input is ignored while it lasts.
//
// Ports
//   clk        system clock, rising edge
//   rts        asynchronous active-low reset
//   enter      one-cycle enter pulse
//   digit_in   switch value sampled with enter
//   logout     one-cycle pulse that revokes access
//   enable     access granted (guess register enable)
//   locked     lockout in progress
//   digit_cnt  digits accepted in the current attempt
//   fail_cnt   consecutive failed attempts
//   pw_bad     one-cycle pulse per failed attempt
//
// state   | meaning
// ENTRY   | collecting digits; logout ignored
// CHECK   | one-cycle verdict on the collected attempt
// GRANTED | access open until logout
// LOCKOUT | keypad ignored for LOCK_CYCLES cycles
module password_access_fsm #(
  parameter logic [3:0] PW_D0       = 4'h5,
  parameter logic [3:0] PW_D1       = 4'h2,
  parameter logic [3:0] PW_D2       = 4'h9,
  parameter logic [3:0] PW_D3       = 4'h3,
  parameter int         MAX_FAIL    = 3,
  parameter int         LOCK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rts,
  input  logic       enter,
  input  logic [3:0] digit_in,
  input  logic       logout,
  output logic       enable,
  output logic       locked,
  output logic [1:0] digit_cnt,
  output logic [1:0] fail_cnt,
  output logic       pw_bad
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CHECK   = 2'd1,
    GRANTED = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     digit_q, digit_d;
  logic [1:0]     fail_q, fail_d;
  logic           mism_q, mism_d;
  logic [LCW-1:0] lock_q, lock_d;
  logic [3:0]     exp_digit;

  always_ff @(posedge clk or negedge rts) begin
    if (!rts) begin
      state_q <= ENTRY;
      digit_q <= '0;
      fail_q  <= '0;
      mism_q  <= 1'b0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      fail_q  <= fail_d;
      mism_q  <= mism_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    exp_digit = PW_D0;
    case (digit_q)
      2'd0:    exp_digit = PW_D0;
      2'd1:    exp_digit = PW_D1;
      2'd2:    exp_digit = PW_D2;
      default: exp_digit = PW_D3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    fail_d  = fail_q;
    mism_d  = mism_q;
    lock_d  = lock_q;
    enable  = 1'b0;
    locked  = 1'b0;
    pw_bad  = 1'b0;

    unique case (state_q)
      ENTRY: begin
        if (enter) begin
          // Sticky flag: every digit is still consumed, so the user
          // cannot tell which position was wrong.
          if (digit_in != exp_digit) mism_d = 1'b1;
          if (digit_q == 2'd3) begin
            digit_d = 2'd0;
            state_d = CHECK;
          end else begin
            digit_d = digit_q + 2'd1;
          end
        end
      end

      CHECK: begin
        mism_d = 1'b0;
        if (!mism_q) begin
          fail_d  = 2'd0;
          state_d = GRANTED;
        end else begin
          pw_bad = 1'b1;
          if (int'(fail_q) + 1 < MAX_FAIL) begin
            fail_d  = fail_q + 2'd1;
            state_d = ENTRY;
          end else begin
            fail_d  = 2'(MAX_FAIL);
            lock_d  = LCW'(LOCK_CYCLES);
            state_d = LOCKOUT;
          end
        end
      end

      GRANTED: begin
        enable = 1'b1;
        // A simultaneous enter belongs to the guess register, never a digit.
        if (logout) begin
          digit_d = 2'd0;
          state_d = ENTRY;
        end
      end

      LOCKOUT: begin
        locked = 1'b1;
        lock_d = lock_q - LCW'(1);
        // Counter loaded with LOCK_CYCLES and leaving on 1 gives exactly
        // LOCK_CYCLES cycles in this state.
        if (lock_q == LCW'(1)) begin
          fail_d  = 2'd0;
          state_d = ENTRY;
        end
      end

      default: state_d = ENTRY;
    endcase
  end

  assign digit_cnt = digit_q;
  assign fail_cnt  = fail_q;

endmodule

// File: doc/password_access_fsm.md
Name: password_access_fsm

Overview:
- Password gate directly upstream of the game's 4-bit guess register.
- The user keys four 4-bit digits on the switches, each confirmed by a one-cycle enter pulse.
- A correct 4-digit sequence raises enable, which unlocks the guess register and the rest of the game until logout.
- Repeated failures put the block into a timed lockout that ignores all keypad input.

Parameters:
- PW_D0, 4'h5, first password digit.
- PW_D1, 4'h2, second password digit.
- PW_D2, 4'h9, third password digit.
- PW_D3, 4'h3, fourth password digit.
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (range 1..3).
- LOCK_CYCLES, 16, lockout duration in clk cycles (≥2; counter width = clog2(LOCK_CYCLES+1)).

Ports:
- clk, input, 1, system clock; this block updates on posedge.
- rts, input, 1, reset; asynchronous, active-low.
- enter, input, 1, already-shaped enter pulse, high for exactly one clk cycle per press.
- digit_in, input, 4, switch value sampled when enter is high.
- logout, input, 1, one-cycle pulse that revokes access.
- enable, output, 1, access granted; drives the guess register's enable.
- locked, output, 1, high during lockout.
- digit_cnt, output, 2, number of digits accepted in the current attempt (0..3).
- fail_cnt, output, 2, consecutive failed attempts.
- pw_bad, output, 1, one-cycle pulse on every failed attempt.

Behaviour:
- Timing
  - All registers update on posedge clk.
  - rts low asynchronously forces the reset state.
  - enable is stable for the whole low phase, so the downstream negedge register samples it cleanly.
- Reset values
  - state = ENTRY.
  - enable = 0, locked = 0, digit_cnt = 0, fail_cnt = 0, pw_bad = 0.
  - mismatch flag = 0, lock counter = 0.
- Reset mid-operation: releasing rts always returns to ENTRY with no access. This includes mid-entry, GRANTED and LOCKOUT; partial digits are discarded.
- States: ENTRY, CHECK, GRANTED, LOCKOUT.
- ENTRY
  - On enter = 1: compare digit_in with PW_D[digit_cnt].
  - Any mismatch sets the sticky mismatch flag. Comparison continues so the user cannot tell which digit failed.
  - After digits 0..2, digit_cnt increments.
  - On the 4th enter, go to CHECK next cycle and set digit_cnt = 0.
  - enter = 0 means hold. logout is ignored in ENTRY.
- CHECK (exactly one cycle; enter is ignored)
  - mismatch = 0: go to GRANTED, fail_cnt = 0, enable = 1 from the next edge.
  - mismatch = 1 and fail_cnt + 1 < MAX_FAIL: pw_bad = 1 for this cycle's output, fail_cnt increments, return to ENTRY.
  - mismatch = 1 and fail_cnt + 1 = MAX_FAIL: pw_bad = 1, fail_cnt = MAX_FAIL, go to LOCKOUT, lock counter = LOCK_CYCLES.
  - Every CHECK clears mismatch.
- Latency: 2 clk from the posedge that samples the 4th correct enter to enable = 1 (capture edge, then CHECK edge).
- GRANTED
  - enable = 1.
  - enter pulses are not interpreted here; they belong to the guess register.
  - logout = 1 at an edge: next state ENTRY, enable = 0, digit_cnt = 0.
  - logout and enter asserted together: logout wins and the enter is not counted as a digit.
- LOCKOUT
  - locked = 1; enter and logout are ignored.
  - Lock counter decrements each cycle.
  - When the counter reads 1: next state ENTRY, locked = 0, fail_cnt = 0.
  - Total time in LOCKOUT is exactly LOCK_CYCLES cycles.
- Success in CHECK always clears fail_cnt; failures need not be consecutive only within one session.
- enable is high only in GRANTED; locked is high only in LOCKOUT.

Test Plan:
- Reset, then enter 5,2,9,3 on consecutive-or-spaced pulses → digit_cnt goes 1,2,3,0; enable = 1 exactly 2 clk after the 4th enter edge; fail_cnt = 0.
- Enter 5,2,9,4 → pw_bad pulses once, fail_cnt = 1, enable stays 0. Then enter 5,2,9,3 → enable = 1, fail_cnt = 0.
- Three wrong attempts (1,1,1,1 ×3) → pw_bad pulses on each; locked = 1 for exactly 16 cycles; enters during lockout are ignored (digit_cnt stays 0). Afterwards fail_cnt = 0 and a correct entry grants access.
- In GRANTED, assert enter with digit_in = 4'hA while logout is held 1 in the same cycle → enable falls next edge, digit_cnt = 0, and a following correct 4-digit entry succeeds.
- Drop rts asynchronously after 2 correct digits, and again mid-lockout → outputs zero immediately without a clock. After release, 5,2,9,3 grants access in the normal 4+2 cycles.
- Wrong first digit, correct rest (7,2,9,3) → still rejected after the 4th enter, not earlier; digit_cnt sequence is identical to a good attempt.
